// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one word-addressed read at a time, buffers
// one fetched word for the downstream consumer, handles branch redirects
// (including squashing an in-flight read) and abandons reads that are never
// acknowledged, flagging a sticky error and retrying from the same pc.
//
// Handshakes:
//   memory    - mem_req_valid is held high for the whole request (REQ/DRAIN)
//               and the memory answers with a single-cycle mem_ack carrying
//               mem_rd_data; acks seen while idle are ignored.
//   downstream - a word moves when instr_valid & instr_ready are both high at
//               a rising clock edge; instr/instr_pc are stable while
//               instr_valid is high and instr_ready is low.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd1,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  output logic        mem_rd_wr,
  output logic [31:0] mem_rd_addr,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_ack,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        fetch_err,
  output logic [15:0] fetch_count,
  output logic [1:0]  dbg_state
);

  // REQ holds a live request; DRAIN holds a request whose data will be dropped
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [15:0] TMO = 16'(TIMEOUT);

  state_t      state;
  logic [31:0] pc;
  logic [15:0] tcnt;
  logic [15:0] tcnt_inc;
  logic        timed_out;
  logic        xfer;

  // Downstream transfer and timeout detection
  assign xfer      = instr_valid & instr_ready;
  assign tcnt_inc  = tcnt + 16'd1;
  assign timed_out = (tcnt_inc == TMO);

  // Fixed read-only request path and debug view of the FSM
  assign mem_rd_wr   = 1'b0;
  assign mem_rd_addr = pc;
  assign dbg_state   = state;

  // Fetch FSM with registered request, output buffer, error flag and counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      tcnt          <= 16'd0;
      mem_req_valid <= 1'b0;
      instr_valid   <= 1'b0;
      instr         <= 32'd0;
      instr_pc      <= 32'd0;
      fetch_err     <= 1'b0;
      fetch_count   <= 16'd0;
    end else begin
      // A transfer empties the buffer; a refill later in this block wins.
      if (xfer) begin
        instr_valid <= 1'b0;
        fetch_count <= fetch_count + 16'd1;
      end

      case (state)
        IDLE: begin
          if (redirect_valid) begin
            pc          <= redirect_pc;
            instr_valid <= 1'b0;
          end else if (!instr_valid || instr_ready) begin
            state         <= REQ;
            mem_req_valid <= 1'b1;
            tcnt          <= 16'd0;
          end
        end

        REQ: begin
          if (redirect_valid && mem_ack) begin
            // Returning word belongs to the old path: drop it.
            pc            <= redirect_pc;
            instr_valid   <= 1'b0;
            state         <= IDLE;
            mem_req_valid <= 1'b0;
          end else if (redirect_valid) begin
            // Keep the request up until the stale ack returns.
            pc          <= redirect_pc;
            instr_valid <= 1'b0;
            state       <= DRAIN;
            tcnt        <= 16'd0;
          end else if (mem_ack) begin
            instr         <= mem_rd_data;
            instr_pc      <= pc;
            instr_valid   <= 1'b1;
            pc            <= pc + PC_STEP;
            state         <= IDLE;
            mem_req_valid <= 1'b0;
          end else if (timed_out) begin
            // Give up; pc is untouched so the next request retries it.
            fetch_err     <= 1'b1;
            state         <= IDLE;
            mem_req_valid <= 1'b0;
          end else begin
            tcnt <= tcnt_inc;
          end
        end

        DRAIN: begin
          if (redirect_valid) begin
            pc          <= redirect_pc;
            instr_valid <= 1'b0;
          end
          if (mem_ack) begin
            state         <= IDLE;
            mem_req_valid <= 1'b0;
          end else if (timed_out) begin
            fetch_err     <= 1'b1;
            state         <= IDLE;
            mem_req_valid <= 1'b0;
          end else begin
            tcnt <= tcnt_inc;
          end
        end

        default: begin
          state         <= IDLE;
          mem_req_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a behavioural word memory answers requests
// with a programmable latency (data = 0xA0 + address), a monitor records
// transfers and request addresses, and one task per scenario checks them.
`timescale 1ns/1ps
module tb_fetch_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic        mem_req_valid;
  logic        mem_rd_wr;
  logic [31:0] mem_rd_addr;
  logic [31:0] mem_rd_data = 32'hDEAD_BEEF;
  logic        mem_ack = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fetch_err;
  logic [15:0] fetch_count;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req_valid  (mem_req_valid),
    .mem_rd_wr      (mem_rd_wr),
    .mem_rd_addr    (mem_rd_addr),
    .mem_rd_data    (mem_rd_data),
    .mem_ack        (mem_ack),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .fetch_err      (fetch_err),
    .fetch_count    (fetch_count),
    .dbg_state      (dbg_state)
  );

  // ---------------- memory model ----------------
  int          mem_lat  = 1;
  bit          mem_dead = 1'b0;
  bit          mem_pend = 1'b0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = 32'd0;
  logic        mem_prev = 1'b0;

  // Reacts to the rising edge of mem_req_valid, acks mem_lat cycles later
  always @(posedge clk) begin
    #1;
    mem_ack     = 1'b0;
    mem_rd_data = 32'hDEAD_BEEF;
    if (mem_req_valid && !mem_prev && !mem_dead) begin
      mem_pend = 1'b1;
      mem_addr = mem_rd_addr;
      mem_cnt  = mem_lat;
    end else if (mem_pend) begin
      mem_cnt = mem_cnt - 1;
    end
    if (mem_pend && mem_cnt == 0) begin
      mem_ack     = 1'b1;
      mem_rd_data = 32'hA0 + mem_addr;
      mem_pend    = 1'b0;
    end
    mem_prev = mem_req_valid;
  end

  // ---------------- monitor ----------------
  logic [31:0] got_instr[$];
  logic [31:0] got_pc[$];
  logic [31:0] req_q[$];
  logic [31:0] exp_q[$];
  bit          log_en   = 1'b1;
  logic        mon_prev = 1'b0;

  // Records each downstream transfer and each new request address
  always @(negedge clk) begin
    if (log_en) begin
      if (instr_valid && instr_ready) begin
        got_instr.push_back(instr);
        got_pc.push_back(instr_pc);
      end
      if (mem_req_valid && !mon_prev) req_q.push_back(mem_rd_addr);
    end
    mon_prev = mem_req_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    repeat (3) cyc();
    got_instr.delete();
    got_pc.delete();
    req_q.delete();
    mem_pend = 1'b0;
    reset    = 1'b1;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (mem_req_valid) begin
        ok = 1'b1;
        return;
      end
      cyc();
    end
  endtask

  task automatic wait_got(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (got_pc.size() >= n) begin
        ok = 1'b1;
        return;
      end
      cyc();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset          = 1'b0;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    mem_lat        = 1;
    repeat (3) cyc();
    total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", mem_req_valid); end
    total++; if (mem_rd_wr !== 1'b0) begin bad++; $display("FAIL reset_rd_wr: got %b want 0", mem_rd_wr); end
    total++; if (mem_rd_addr !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want 0", mem_rd_addr); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid); end
    total++; if (instr !== 32'h0) begin bad++; $display("FAIL reset_instr: got %h want 0", instr); end
    total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL reset_instr_pc: got %h want 0", instr_pc); end
    total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", fetch_err); end
    total++; if (fetch_count !== 16'h0) begin bad++; $display("FAIL reset_count: got %h want 0", fetch_count); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
  endtask

  task automatic test_stream();
    bit ok;
    instr_ready = 1'b1;
    mem_lat     = 1;
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hA0 + i);
    wait_got(4, 100, ok);
    instr_ready = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL stream_timeout: got %0d transfers want 4", got_pc.size()); end
    repeat (6) cyc();
    if (ok) begin
      for (int i = 0; i < 4; i++) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        total++; if (got_instr[i] !== e) begin bad++; $display("FAIL stream_instr%0d: got %h want %h", i, got_instr[i], e); end
        total++; if (got_pc[i] !== 32'(i)) begin bad++; $display("FAIL stream_pc%0d: got %h want %h", i, got_pc[i], i); end
        total++; if (req_q[i] !== 32'(i)) begin bad++; $display("FAIL stream_addr%0d: got %h want %h", i, req_q[i], i); end
      end
    end
    total++; if (fetch_count !== 16'd4) begin bad++; $display("FAIL stream_count: got %0d want 4", fetch_count); end
  endtask

  task automatic test_stall();
    bit ok;
    instr_ready = 1'b0;
    mem_lat     = 1;
    do_reset();
    wait_req(ok);
    total++; if (!ok) begin bad++; $display("FAIL stall_no_req: got 0 want 1"); end
    repeat (14) cyc();
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL stall_valid: got %b want 1", instr_valid); end
    total++; if (instr !== 32'hA0) begin bad++; $display("FAIL stall_instr: got %h want a0", instr); end
    total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL stall_pc: got %h want 0", instr_pc); end
    total++; if (req_q.size() !== 1) begin bad++; $display("FAIL stall_req_count: got %0d want 1", req_q.size()); end
    instr_ready = 1'b1;
    wait_got(2, 50, ok);
    total++; if (!ok) begin bad++; $display("FAIL stall_resume: got %0d transfers want 2", got_pc.size()); end
    if (ok) begin
      total++; if (got_instr[0] !== 32'hA0) begin bad++; $display("FAIL stall_first: got %h want a0", got_instr[0]); end
      total++; if (got_instr[1] !== 32'hA1) begin bad++; $display("FAIL stall_second: got %h want a1", got_instr[1]); end
      total++; if (got_pc[1] !== 32'h1) begin bad++; $display("FAIL stall_second_pc: got %h want 1", got_pc[1]); end
    end
  endtask

  task automatic test_redirect_req();
    bit ok;
    instr_ready = 1'b1;
    mem_lat     = 4;
    do_reset();
    wait_req(ok);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h20;
    cyc();
    redirect_valid = 1'b0;
    total++; if (dbg_state !== 2'd2) begin bad++; $display("FAIL redir_req_drain: got %0d want 2", dbg_state); end
    wait_got(1, 60, ok);
    total++; if (!ok) begin bad++; $display("FAIL redir_req_timeout: got 0 transfers want 1"); end
    if (ok) begin
      total++; if (got_pc[0] !== 32'h20) begin bad++; $display("FAIL redir_req_pc: got %h want 20", got_pc[0]); end
      total++; if (got_instr[0] !== 32'hC0) begin bad++; $display("FAIL redir_req_instr: got %h want c0", got_instr[0]); end
      total++; if (req_q.size() < 2 || req_q[1] !== 32'h20) begin bad++; $display("FAIL redir_req_addr: got %0d reqs want second addr 20", req_q.size()); end
    end
    mem_lat = 1;
  endtask

  task automatic test_redirect_ack();
    bit ok;
    instr_ready = 1'b1;
    mem_lat     = 1;
    do_reset();
    wait_req(ok);
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    cyc();
    redirect_valid = 1'b0;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL redir_ack_valid: got %b want 0", instr_valid); end
    total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL redir_ack_idle: got %b want 0", mem_req_valid); end
    wait_got(1, 40, ok);
    total++; if (!ok) begin bad++; $display("FAIL redir_ack_timeout: got 0 transfers want 1"); end
    if (ok) begin
      total++; if (got_pc[0] !== 32'h40) begin bad++; $display("FAIL redir_ack_pc: got %h want 40", got_pc[0]); end
      total++; if (got_instr[0] !== 32'hE0) begin bad++; $display("FAIL redir_ack_instr: got %h want e0", got_instr[0]); end
      total++; if (req_q.size() < 2 || req_q[1] !== 32'h40) begin bad++; $display("FAIL redir_ack_addr: got %0d reqs want second addr 40", req_q.size()); end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    instr_ready = 1'b1;
    mem_dead    = 1'b1;
    do_reset();
    wait_req(ok);
    total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL tmo_early_err: got %b want 0", fetch_err); end
    n = 0;
    while (mem_req_valid && n < 40) begin
      n++;
      cyc();
    end
    total++; if (n !== 16) begin bad++; $display("FAIL tmo_cycles: got %0d want 16", n); end
    total++; if (fetch_err !== 1'b1) begin bad++; $display("FAIL tmo_err: got %b want 1", fetch_err); end
    total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL tmo_drop: got %b want 0", mem_req_valid); end
    wait_req(ok);
    total++; if (!ok || mem_rd_addr !== 32'h0) begin bad++; $display("FAIL tmo_retry_addr: got %h want 0", mem_rd_addr); end
    repeat (5) cyc();
    total++; if (fetch_err !== 1'b1) begin bad++; $display("FAIL tmo_sticky: got %b want 1", fetch_err); end
    total++; if (got_pc.size() !== 0) begin bad++; $display("FAIL tmo_no_xfer: got %0d want 0", got_pc.size()); end
    mem_dead = 1'b0;
    do_reset();
    total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL tmo_reset_clear: got %b want 0", fetch_err); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    instr_ready = 1'b1;
    mem_lat     = 3;
    do_reset();
    wait_req(ok);
    cyc();
    reset = 1'b0;
    cyc();
    total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL midrst_drop: got %b want 0", mem_req_valid); end
    cyc();
    reset = 1'b1;
    cyc();
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL midrst_late_ack: got %b want 0", instr_valid); end
    total++; if (fetch_count !== 16'd0) begin bad++; $display("FAIL midrst_count: got %0d want 0", fetch_count); end
    wait_got(1, 40, ok);
    total++; if (!ok || got_instr[0] !== 32'hA0 || got_pc[0] !== 32'h0) begin bad++; $display("FAIL midrst_refetch: got %0d transfers want a0 at 0", got_pc.size()); end
    mem_lat = 1;
  endtask

  task automatic test_wrap();
    int n;
    instr_ready = 1'b1;
    mem_lat     = 0;
    log_en      = 1'b0;
    do_reset();
    n = 0;
    for (int i = 0; i < 140000 && n < 65537; i++) begin
      @(negedge clk);
      if (instr_valid && instr_ready) begin
        n++;
        if (n == 65536) begin
          total++; if (fetch_count !== 16'hFFFF) begin bad++; $display("FAIL wrap_max: got %h want ffff", fetch_count); end
        end
        if (n == 65537) begin
          total++; if (fetch_count !== 16'h0000) begin bad++; $display("FAIL wrap_zero: got %h want 0", fetch_count); end
        end
      end
    end
    @(posedge clk);
    #1;
    instr_ready = 1'b0;
    repeat (4) cyc();
    total++; if (n !== 65537) begin bad++; $display("FAIL wrap_budget: got %0d want 65537", n); end
    total++; if (fetch_count !== 16'h0001) begin bad++; $display("FAIL wrap_final: got %h want 0001", fetch_count); end
    log_en  = 1'b1;
    mem_lat = 1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_req();
    test_redirect_ack();
    test_timeout();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
